console_uart_tx: RTL and testbench
==================================

// Module: console_uart_tx
// PURPOSE
//   Consumes the core's console byte stream (console_we/console_wdata) and
//   serialises it onto a UART TX pin, 8N1, LSB first. A small FIFO absorbs
//   bursts of console stores so the core never stalls. It sits beside
//   seven_seg as a second peripheral sink on the FPGA top.
// PARAMETERS
//   CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); must be >= 2
//   FIFO_DEPTH    16   byte entries; power of two, >= 2
//   XLEN          32   console_wdata width; only bits [7:0] are transmitted
// PORTS
//   clk            in   1     system clock; all state updates on rising edge
//   reset          in   1     asynchronous, active-low reset
//   console_we     in   1     one-cycle write strobe from the core
//   console_wdata  in   XLEN  write data; [7:0] is the byte, upper bits ignored
//   tx             out  1     UART serial output, idle high
//   busy           out  1     high while a frame is on the line or FIFO non-empty
//   fifo_full      out  1     high when FIFO holds FIFO_DEPTH bytes
//   overflow       out  1     sticky: a write was dropped because FIFO was full
// BEHAVIOUR
//   Reset (reset==0, async): tx=1, busy=0, fifo_full=0, overflow=0, FIFO
//     empty, FSM=IDLE, baud and bit counters 0. A frame in flight is
//     abandoned; tx returns high immediately, with no partial stop bit.
//   FIFO: circular buffer, rd/wr pointers of log2(FIFO_DEPTH) bits that wrap
//     modulo FIFO_DEPTH, plus a count of log2(FIFO_DEPTH)+1 bits.
//     Write when console_we=1 and count<FIFO_DEPTH before the edge. If
//     console_we=1 while full, the byte is dropped and overflow is set to 1.
//     overflow stays 1 until reset. A pop in the same cycle does not rescue
//     a write to a full FIFO: full is judged on the pre-edge count.
//     Simultaneous push and pop on a non-full FIFO leaves count unchanged.
//   FSM states: IDLE, START, DATA, STOP.
//     IDLE : tx=1. If the FIFO is non-empty, pop the head into shift register
//            sh[7:0], clear the counters and go to START.
//     START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
//     DATA : tx=sh[0] for CLKS_PER_BIT cycles, then shift sh right and
//            increment bit_idx. After bit_idx==7 completes, go to STOP.
//     STOP : tx=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty,
//            pop and go straight to START with no idle gap; else go to IDLE.
//   Baud counter: runs 0..CLKS_PER_BIT-1. A bit ends when it reaches
//     CLKS_PER_BIT-1; the counter then wraps to 0.
//   tx is a registered output with no combinational path from inputs.
//   Latency: console_we is sampled at edge E. The FIFO is non-empty after E.
//     At edge E+1 the FSM pops and enters START, so tx goes low after E+1.
//     A full frame lasts exactly 10*CLKS_PER_BIT cycles.
//   busy = (state != IDLE) | (count != 0). fifo_full = (count == FIFO_DEPTH).
//   Byte order on the line equals console write order; no byte is duplicated.
// TESTING
//   (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated)
//   1 Reset: hold reset=0 mid-frame -> tx=1, busy=0, overflow=0 at once; after
//     release, tx stays 1 with no stray frame.
//   2 Single byte: write 0x000000A5 at edge E -> tx low from E+1 for 4 cycles,
//     then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop high;
//     busy falls after 40 cycles.
//   3 Upper bits ignored: write 0xDEADBE41 -> serial byte decodes as 0x41.
//   4 Burst: write 0x11,0x22,0x33 on consecutive cycles -> three
//     back-to-back frames with no idle gap between stop and start, in order.
//   5 Overflow: one frame in flight, then 5 writes on consecutive cycles ->
//     fifo_full=1 after the 4th, 5th byte dropped, overflow=1; 5 frames
//     total (in-flight + 4 queued).
//   6 Wrap-around: stream 10 bytes 0x00..0x09, each written only when
//     fifo_full=0 -> all 10 received in order; pointers wrap twice.

Source files
------------

// File: rtl/console_uart_tx.sv
// Generic circular-buffer FIFO: push is dropped (drop pulses) when full on the pre-edge count.
// Latency: a pushed entry is visible at head_dat one cycle after the push edge.
// Backpressure: none upstream; producer sees count/drop, consumer pops only when non-empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok  = push_vld && (count_q != FULL_CNT);
        pop_ok   = pop_rdy && (count_q != '0);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) count_d = count_q + 1'b1;
        if (!push_ok && pop_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign drop     = push_vld && (count_q == FULL_CNT);
endmodule

// Console byte sink: buffers core console stores and shifts them out as 8N1 UART, LSB first.
// Latency: write at edge E, start bit driven from E+1; each frame is 10*CLKS_PER_BIT cycles.
// Backpressure: core never stalls; writes to a full FIFO are dropped and flag sticky overflow.
module console_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            console_we,
    input  logic [XLEN-1:0] console_wdata,
    output logic            tx,
    output logic            busy,
    output logic            fifo_full,
    output logic            overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          overflow_q, overflow_d;

    logic          fifo_pop;
    logic [7:0]    fifo_head_dat;
    logic [AW:0]   fifo_cnt;
    logic          fifo_drop;
    logic          baud_end;
    logic          unused_wdata;

    assign unused_wdata = ^console_wdata[XLEN-1:8];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (console_we),
        .push_dat (console_wdata[7:0]),
        .pop_rdy  (fifo_pop),
        .head_dat (fifo_head_dat),
        .count    (fifo_cnt),
        .drop     (fifo_drop)
    );

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        sh_d       = sh_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        overflow_d = overflow_q | fifo_drop;
        baud_end   = (baud_q == BAUD_LAST);

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (fifo_cnt != '0) begin
                    fifo_pop  = 1'b1;
                    sh_d      = fifo_head_dat;
                    baud_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = sh_q[0];
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    sh_d   = {1'b0, sh_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // tx is registered, so present the bit that the shift is about to expose.
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = sh_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (fifo_cnt != '0) begin
                        fifo_pop  = 1'b1;
                        sh_d      = fifo_head_dat;
                        bit_idx_d = '0;
                        tx_d      = 1'b0;
                        state_d   = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            sh_q       <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            sh_q       <= sh_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = (state_q != IDLE) || (fifo_cnt != '0);
    assign fifo_full = (fifo_cnt == FULL_CNT);
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_console_uart_tx.sv
module tb_console_uart_tx;
    localparam int CPB = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        console_we = 1'b0;
    logic [31:0] console_wdata = '0;
    logic        tx, busy, fifo_full, overflow;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    logic rx_en = 1'b0;
    logic [7:0] rx_q[$];
    int rx_cyc_q[$];

    console_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .XLEN(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .console_we    (console_we),
        .console_wdata (console_wdata),
        .tx            (tx),
        .busy          (busy),
        .fifo_full     (fifo_full),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_byte(input logic [31:0] d);
        @(negedge clk);
        console_we    = 1'b1;
        console_wdata = d;
        @(posedge clk);
        #1;
        console_we = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int w;
        for (w = 0; w < 2000; w++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (w >= 2000) chk({tag, "_timeout"}, 32'd1, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = 8'hxx;
        if (rx_q.size() > 0) got = rx_q.pop_front();
        chk(tag, {24'd0, got}, {24'd0, exp});
    endtask

    // Line receiver: samples mid-bit (offset 2 of each 4-cycle bit) from the first low cycle.
    initial begin : rx_mon
        logic [7:0] b;
        int sc;
        forever begin
            @(negedge clk);
            if (rx_en && reset && tx == 1'b0) begin
                sc = cyc;
                repeat (2) @(negedge clk);
                chk("rx_start", {31'd0, tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                chk("rx_stop", {31'd0, tx}, 32'd1);
                rx_q.push_back(b);
                rx_cyc_q.push_back(sc);
                @(negedge clk);
            end
        end
    end

    initial begin
        logic [9:0] frame_bits;
        int low_seen;
        int g1, g2;

        // Reset state, then reset abandoning a frame mid-flight.
        #12;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_full", {31'd0, fifo_full}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        write_byte(32'h0000_0000);
        repeat (10) @(negedge clk);
        chk("t1_midframe_tx", {31'd0, tx}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("t1_async_tx", {31'd0, tx}, 32'd1);
        chk("t1_async_busy", {31'd0, busy}, 32'd0);
        chk("t1_async_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        low_seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) low_seen++;
        end
        chk("t1_no_stray", low_seen, 32'd0);
        rx_en = 1'b1;

        // Single byte 0xA5, checked every cycle of the frame.
        frame_bits = {1'b1, 8'hA5, 1'b0};
        write_byte(32'h0000_00A5);
        @(negedge clk);
        chk("t2_tx_before_start", {31'd0, tx}, 32'd1);
        chk("t2_busy_queued", {31'd0, busy}, 32'd1);
        @(posedge clk);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            chk($sformatf("t2_bit%0d_cyc%0d", k / CPB, k % CPB), {31'd0, tx}, {31'd0, frame_bits[k / CPB]});
        end
        chk("t2_busy_last", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t2_busy_fall", {31'd0, busy}, 32'd0);
        wait_idle("t2");
        chk("t2_count", rx_q.size(), 32'd1);
        expect_rx("t2_byte", 8'hA5);
        rx_cyc_q.delete();

        // Upper data bits ignored.
        write_byte(32'hDEAD_BE41);
        wait_idle("t3");
        chk("t3_count", rx_q.size(), 32'd1);
        expect_rx("t3_byte", 8'h41);
        rx_cyc_q.delete();

        // Burst of three: back-to-back frames in order.
        write_byte(32'h11);
        write_byte(32'h22);
        write_byte(32'h33);
        wait_idle("t4");
        chk("t4_count", rx_q.size(), 32'd3);
        g1 = (rx_cyc_q.size() >= 3) ? rx_cyc_q[1] - rx_cyc_q[0] : -1;
        g2 = (rx_cyc_q.size() >= 3) ? rx_cyc_q[2] - rx_cyc_q[1] : -1;
        chk("t4_gap01", g1, FRAME);
        chk("t4_gap12", g2, FRAME);
        expect_rx("t4_b0", 8'h11);
        expect_rx("t4_b1", 8'h22);
        expect_rx("t4_b2", 8'h33);
        rx_cyc_q.delete();

        // Overflow: one frame in flight plus five writes into a depth-4 FIFO.
        write_byte(32'h55);
        begin
            int w;
            for (w = 0; w < 10; w++) begin
                @(negedge clk);
                if (tx == 1'b0) break;
            end
            if (w >= 10) chk("t5_start_timeout", 32'd1, 32'd0);
        end
        write_byte(32'h61);
        write_byte(32'h62);
        write_byte(32'h63);
        chk("t5_full_after3", {31'd0, fifo_full}, 32'd0);
        write_byte(32'h64);
        chk("t5_full_after4", {31'd0, fifo_full}, 32'd1);
        chk("t5_ovf_after4", {31'd0, overflow}, 32'd0);
        write_byte(32'h65);
        chk("t5_ovf_after5", {31'd0, overflow}, 32'd1);
        wait_idle("t5");
        chk("t5_ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("t5_count", rx_q.size(), 32'd5);
        expect_rx("t5_b0", 8'h55);
        expect_rx("t5_b1", 8'h61);
        expect_rx("t5_b2", 8'h62);
        expect_rx("t5_b3", 8'h63);
        expect_rx("t5_b4", 8'h64);
        rx_cyc_q.delete();

        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("t5_ovf_cleared", {31'd0, overflow}, 32'd0);

        // Ten bytes throttled on fifo_full: pointers wrap twice.
        for (int i = 0; i < 10; i++) begin
            int w;
            for (w = 0; w < 500 && fifo_full; w++) @(negedge clk);
            if (w >= 500) chk("t6_full_timeout", 32'd1, 32'd0);
            write_byte(i);
        end
        wait_idle("t6");
        chk("t6_count", rx_q.size(), 32'd10);
        chk("t6_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 10; i++) expect_rx($sformatf("t6_b%0d", i), 8'(i));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got expired expected finish");
        $fatal(1);
    end
endmodule
